gen_read_logic: RTL

Read-side address generator and stream-out engine for the capture buffer. After the write side has filled the 32K-entry capture RAM (`wr_done`), it reads every entry in order, 0x0000 to 0x7FFF, and presents the words on a valid/ready stream to the packet controller. It absorbs the RAM read latency and downstream back-pressure in a small output FIFO, then flags `rd_done` when the last word has been accepted.

---
 rtl/pktctrl_pkg.sv | 20 ++
 rtl/gen_read_fifo.sv | 83 ++++++++
 rtl/jlsemi_util_sync_pos_with_rst_low.sv | 28 ++
 rtl/gen_read_logic.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pktctrl_pkg.sv
// Shared definitions for the packet-controller capture path.
// Provides the read-side FSM state encoding, the capture RAM address width
// and a small helper that decodes the busy flag from a state.
package pktctrl_pkg;

  localparam int unsigned CAP_AW = 15;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_WAIT_WR,
    RD_READ,
    RD_DRAIN,
    RD_DONE
  } rd_state_e;

  function automatic logic state_is_busy(input rd_state_e s);
    return (s != RD_IDLE) && (s != RD_DONE);
  endfunction

endpackage

// File: rtl/gen_read_fifo.sv
// Synchronous show-ahead FIFO used as the read-side output buffer.
// Ports: clk, rstn (async active-low), flush (clears contents, wins over
//        push/pop), push/din (write), pop (read; dout shows head entry),
//        count (occupancy), empty, full.
module gen_read_fifo #(
  parameter  int unsigned DW         = 16,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/jlsemi_util_sync_pos_with_rst_low.sv
// Two-flop level synchronizer for a single asynchronous bit.
// Ports: clk (destination clock), rst_n (async active-low reset),
//        d (asynchronous input), q (synchronized output, resets to 0).
module jlsemi_util_sync_pos_with_rst_low (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/gen_read_logic.sv
// Read-side address generator and stream-out engine for the capture buffer.
// Once the write side reports completion it reads every RAM entry in order
// and streams the words out on a valid/ready interface, buffering RAM read
// latency and back-pressure in a small show-ahead FIFO.
// Ports: clk, rstn (async active-low); rf_capture_start / rf_read_start /
//        wr_done (asynchronous levels, synchronized here); ren/raddr/rdata
//        (RAM read port); dout_vld/dout/dout_rdy (output stream);
//        rd_busy (active run), rd_done (sticky completion flag).
module gen_read_logic
  import pktctrl_pkg::*;
#(
  parameter int unsigned AW         = CAP_AW,
  parameter int unsigned DW         = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rf_capture_start,
  input  logic          rf_read_start,
  input  logic          wr_done,
  output logic          ren,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          dout_vld,
  output logic [DW-1:0] dout,
  input  logic          dout_rdy,
  output logic          rd_busy,
  output logic          rd_done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic              cap_sync, rd_start_sync, wr_done_sync;
  logic              rd_start_prev_q, rd_start_prev_d;
  logic              start_p_q, start_p_d;
  rd_state_e         state_q, state_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [1:0]        inflight_q, inflight_d;
  logic [RD_LAT-1:0] lat_q, lat_d;
  logic              rd_busy_q, rd_busy_d;
  logic              rd_done_q, rd_done_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic              fifo_push, fifo_pop;
  logic              ren_c, ret_strobe, drain_done;
  logic [OW-1:0]     occupancy;

  jlsemi_util_sync_pos_with_rst_low u_sync_cap (
    .clk  (clk),
    .rst_n(rstn),
    .d    (rf_capture_start),
    .q    (cap_sync)
  );

  jlsemi_util_sync_pos_with_rst_low u_sync_start (
    .clk  (clk),
    .rst_n(rstn),
    .d    (rf_read_start),
    .q    (rd_start_sync)
  );

  jlsemi_util_sync_pos_with_rst_low u_sync_wr (
    .clk  (clk),
    .rst_n(rstn),
    .d    (wr_done),
    .q    (wr_done_sync)
  );

  gen_read_fifo #(
    .DW        (DW),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .flush(cap_sync),
    .push (fifo_push),
    .din  (rdata),
    .pop  (fifo_pop),
    .dout (dout),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Outstanding reads are counted against FIFO space so returning data
  // always has a slot to land in.
  assign occupancy  = OW'(fifo_count) + OW'(inflight_q);
  assign ren_c      = (state_q == RD_READ) && !cap_sync && !fifo_full &&
                      (occupancy < OW'(FIFO_DEPTH));
  assign ret_strobe = lat_q[RD_LAT-1];
  assign fifo_push  = ret_strobe & ~cap_sync;
  assign fifo_pop   = ~fifo_empty & dout_rdy;

  // Looks ahead at the pop of the final word so rd_done rises on the same
  // edge that completes the last handshake.
  assign drain_done = (inflight_q == 2'd0) &&
                      (fifo_empty || ((fifo_count == CW'(1)) && fifo_pop));

  always_comb begin
    state_d         = state_q;
    raddr_d         = raddr_q;
    inflight_d      = inflight_q;
    rd_done_d       = rd_done_q;
    rd_start_prev_d = rd_start_sync;
    start_p_d       = rd_start_sync & ~rd_start_prev_q;

    lat_d    = lat_q;
    lat_d[0] = ren_c;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end

    if (ren_c) begin
      raddr_d = raddr_q + AW'(1);
    end

    case ({ren_c, ret_strobe})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      RD_IDLE, RD_DONE: begin
        if (start_p_q) begin
          state_d   = RD_WAIT_WR;
          rd_done_d = 1'b0;
        end
      end
      RD_WAIT_WR: begin
        if (wr_done_sync) begin
          state_d = RD_READ;
        end
      end
      RD_READ: begin
        if (ren_c && (raddr_q == '1)) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (drain_done) begin
          state_d   = RD_DONE;
          rd_done_d = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // Capture restart overrides everything, including a coincident start.
    if (cap_sync) begin
      state_d    = RD_IDLE;
      raddr_d    = '0;
      inflight_d = '0;
      lat_d      = '0;
      rd_done_d  = 1'b0;
    end

    rd_busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= RD_IDLE;
      raddr_q         <= '0;
      inflight_q      <= '0;
      lat_q           <= '0;
      rd_start_prev_q <= 1'b0;
      start_p_q       <= 1'b0;
      rd_busy_q       <= 1'b0;
      rd_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      inflight_q      <= inflight_d;
      lat_q           <= lat_d;
      rd_start_prev_q <= rd_start_prev_d;
      start_p_q       <= start_p_d;
      rd_busy_q       <= rd_busy_d;
      rd_done_q       <= rd_done_d;
    end
  end

  assign ren      = ren_c;
  assign raddr    = raddr_q;
  assign dout_vld = ~fifo_empty;
  assign rd_busy  = rd_busy_q;
  assign rd_done  = rd_done_q;

endmodule
